// File: rtl/instr_fetch.sv
// rtl/instr_fetch.sv - IF-stage fetch unit with a single-outstanding imem request
//
// Owns the PC and fetches one instruction at a time over a req/ready + rvalid
// handshake. The fetched word and its incremented PC are presented as registered
// values to the IF/ID pipeline register. When there is no valid instruction, an
// all-zero word (NOP) is presented instead.
//
// Ports
//   clk               in   1    clock, rising edge
//   reset             in   1    asynchronous, active-low reset
//   stall             in   1    hold the presented instruction (IF/ID stall)
//   redirect          in   1    load redirect_pc, kill presented and in-flight fetch
//   redirect_pc       in   LEN  redirect target
//   imem_req          out  1    request valid (only in REQ)
//   imem_addr         out  LEN  request address, zero when imem_req is low
//   imem_ready        in   1    memory accepts the request this cycle
//   imem_rvalid       in   1    response valid
//   imem_rdata        in   LEN  response instruction word
//   next_inced_pc     out  LEN  fetched PC + PC_INC, zero when not fetch_valid
//   next_instruction  out  LEN  fetched word, zero (NOP) when not fetch_valid
//   fetch_valid       out  1    next_instruction holds a real instruction
module instr_fetch #(
    parameter int unsigned      LEN      = 32,
    parameter logic [LEN-1:0]   RESET_PC = '0,
    parameter logic [LEN-1:0]   PC_INC   = LEN'(4)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           stall,
    input  logic           redirect,
    input  logic [LEN-1:0] redirect_pc,
    output logic           imem_req,
    output logic [LEN-1:0] imem_addr,
    input  logic           imem_ready,
    input  logic           imem_rvalid,
    input  logic [LEN-1:0] imem_rdata,
    output logic [LEN-1:0] next_inced_pc,
    output logic [LEN-1:0] next_instruction,
    output logic           fetch_valid
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_REQ  = 3'd1,
        S_WAIT = 3'd2,
        S_HAVE = 3'd3,
        S_DROP = 3'd4
    } state_t;

    state_t         state, state_d;
    logic [LEN-1:0] pc, pc_d;
    logic [LEN-1:0] inced_d;
    logic [LEN-1:0] instr_d;
    logic           valid_d;
    logic [LEN-1:0] pc_inc;
    logic           resp_pending;

    // Wraps modulo 2^LEN by construction of the width.
    assign pc_inc = pc + PC_INC;

    // A redirect must not let a response that is still on its way be mistaken
    // for the redirect target's instruction. This is true when a request has
    // been accepted (or is being accepted now) and its data has not arrived by
    // the redirect edge.
    assign resp_pending = ((state == S_WAIT) && !imem_rvalid) ||
                          ((state == S_REQ)  &&  imem_ready)  ||
                          ((state == S_DROP) && !imem_rvalid);

    assign imem_req  = (state == S_REQ);
    assign imem_addr = imem_req ? pc : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state            <= S_IDLE;
            pc               <= RESET_PC;
            next_inced_pc    <= '0;
            next_instruction <= '0;
            fetch_valid      <= 1'b0;
        end else begin
            state            <= state_d;
            pc               <= pc_d;
            next_inced_pc    <= inced_d;
            next_instruction <= instr_d;
            fetch_valid      <= valid_d;
        end
    end

    always_comb begin
        state_d = state;
        pc_d    = pc;
        inced_d = next_inced_pc;
        instr_d = next_instruction;
        valid_d = fetch_valid;

        if (state == S_IDLE) begin
            // Redirects are ignored here; the first request always leaves
            // one cycle after reset release.
            state_d = S_REQ;
        end else if (redirect) begin
            // Takes precedence over stall and over a coincident response.
            pc_d    = redirect_pc;
            valid_d = 1'b0;
            inced_d = '0;
            instr_d = '0;
            state_d = resp_pending ? S_DROP : S_REQ;
        end else begin
            case (state)
                S_REQ: begin
                    if (imem_ready) begin
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    // Captured regardless of stall: nothing is presented yet.
                    if (imem_rvalid) begin
                        instr_d = imem_rdata;
                        inced_d = pc_inc;
                        valid_d = 1'b1;
                        pc_d    = pc_inc;
                        state_d = S_HAVE;
                    end
                end
                S_HAVE: begin
                    // Without stall, IF/ID takes the instruction at this edge.
                    if (!stall) begin
                        valid_d = 1'b0;
                        inced_d = '0;
                        instr_d = '0;
                        state_d = S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_rvalid) begin
                        state_d = S_REQ;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// tb/tb_instr_fetch.sv - scoreboard testbench for instr_fetch
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] next_inced_pc;
    logic [31:0] next_instruction;
    logic        fetch_valid;

    logic        imem_req_w;
    logic [31:0] imem_addr_w;
    logic [31:0] next_inced_pc_w;
    logic [31:0] next_instruction_w;
    logic        fetch_valid_w;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct {
        logic [31:0] inced;
        logic [31:0] instr;
    } exp_t;

    exp_t exp_q[$];
    logic fv_prev;

    instr_fetch #(.LEN(32), .RESET_PC(32'h0000_0000), .PC_INC(32'd4)) u_dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req),
        .imem_addr        (imem_addr),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .next_inced_pc    (next_inced_pc),
        .next_instruction (next_instruction),
        .fetch_valid      (fetch_valid)
    );

    // Same stimulus, PC starting just below the wrap point.
    instr_fetch #(.LEN(32), .RESET_PC(32'hFFFF_FFFC), .PC_INC(32'd4)) u_dut_wrap (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .redirect         (redirect),
        .redirect_pc      (redirect_pc),
        .imem_req         (imem_req_w),
        .imem_addr        (imem_addr_w),
        .imem_ready       (imem_ready),
        .imem_rvalid      (imem_rvalid),
        .imem_rdata       (imem_rdata),
        .next_inced_pc    (next_inced_pc_w),
        .next_instruction (next_instruction_w),
        .fetch_valid      (fetch_valid_w)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pops the scoreboard whenever a new instruction appears on the outputs.
    always @(negedge clk) begin
        if (!reset) begin
            fv_prev <= 1'b0;
        end else begin
            if (fetch_valid && !fv_prev) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_fetch", 32'(fetch_valid), 32'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sb_instr", next_instruction, e.instr);
                    check("sb_inced", next_inced_pc, e.inced);
                end
            end
            fv_prev <= fetch_valid;
        end
    end

    // Starts in REQ; ends in HAVE with the word presented.
    task automatic fetch_to_have(input logic [31:0] addr, input logic [31:0] word,
                                 input int ready_dly, input int rvalid_dly);
        exp_t e;
        check("req_hi", 32'(imem_req), 32'd1);
        check("req_addr", imem_addr, addr);
        for (int i = 0; i < ready_dly; i++) begin
            imem_ready = 1'b0;
            tick();
            check("req_hold", imem_addr, addr);
        end
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        check("wait_req_lo", 32'(imem_req), 32'd0);
        for (int i = 0; i < rvalid_dly; i++) begin
            tick();
            check("wait_nop", next_instruction, 32'd0);
        end
        imem_rvalid = 1'b1;
        imem_rdata  = word;
        e.inced = addr + 32'd4;
        e.instr = word;
        exp_q.push_back(e);
        tick();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        check("have_valid", 32'(fetch_valid), 32'd1);
    endtask

    // Starts in HAVE; holds for n stalled cycles, then lets IF/ID consume.
    task automatic consume(input logic [31:0] word, input logic [31:0] inced,
                           input int n, input logic [31:0] next_addr);
        stall = 1'b1;
        for (int i = 0; i < n; i++) begin
            tick();
            check("stall_valid", 32'(fetch_valid), 32'd1);
            check("stall_instr", next_instruction, word);
            check("stall_inced", next_inced_pc, inced);
            check("stall_req_lo", 32'(imem_req), 32'd0);
        end
        stall = 1'b0;
        tick();
        check("cons_valid", 32'(fetch_valid), 32'd0);
        check("cons_instr", next_instruction, 32'd0);
        check("cons_inced", next_inced_pc, 32'd0);
        check("next_req", 32'(imem_req), 32'd1);
        check("next_addr", imem_addr, next_addr);
    endtask

    initial begin
        reset       = 1'b0;
        stall       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'd0;
        imem_ready  = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'd0;
        tick();
        tick();
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", imem_addr, 32'd0);
        check("rst_valid", 32'(fetch_valid), 32'd0);
        check("rst_instr", next_instruction, 32'd0);
        check("rst_inced", next_inced_pc, 32'd0);

        reset = 1'b1;
        check("idle_req", 32'(imem_req), 32'd0);
        tick();

        // Basic fetch; wrap instance sees the same handshake from 0xFFFFFFFC.
        check("wrap_addr0", imem_addr_w, 32'hFFFF_FFFC);
        fetch_to_have(32'h0, 32'h2008_0005, 0, 0);
        check("wrap_inced", next_inced_pc_w, 32'h0);
        check("wrap_instr", next_instruction_w, 32'h2008_0005);
        consume(32'h2008_0005, 32'h4, 0, 32'h4);
        check("wrap_next_addr", imem_addr_w, 32'h0);
        check("wrap_next_req", 32'(imem_req_w), 32'd1);

        // Stall in HAVE for 5 cycles.
        fetch_to_have(32'h4, 32'h0043_0820, 0, 0);
        consume(32'h0043_0820, 32'h8, 5, 32'h8);

        // Slow memory; stall in WAIT must not matter.
        stall = 1'b1;
        fetch_to_have(32'h8, 32'h8C22_0000, 2, 3);
        stall = 1'b0;
        consume(32'h8C22_0000, 32'hC, 0, 32'hC);

        // Redirect in WAIT; stale response arrives two cycles later.
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h100;
        tick();
        redirect = 1'b0;
        check("drop_req_lo", 32'(imem_req), 32'd0);
        check("drop_valid", 32'(fetch_valid), 32'd0);
        tick();
        check("drop_req_lo2", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
        tick();
        imem_rvalid = 1'b0;
        check("drop_valid2", 32'(fetch_valid), 32'd0);
        check("redir_req", 32'(imem_req), 32'd1);
        check("redir_addr", imem_addr, 32'h100);

        // Redirect while the request is being accepted.
        imem_ready  = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h200;
        tick();
        imem_ready = 1'b0;
        redirect   = 1'b0;
        check("reqacc_drop", 32'(imem_req), 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0001;
        tick();
        imem_rvalid = 1'b0;
        check("reqacc_valid", 32'(fetch_valid), 32'd0);
        check("reqacc_addr", imem_addr, 32'h200);

        // Redirect coinciding with the response: straight back to REQ.
        imem_ready = 1'b1;
        tick();
        imem_ready  = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h300;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0BAD_0002;
        tick();
        redirect    = 1'b0;
        imem_rvalid = 1'b0;
        check("coinc_valid", 32'(fetch_valid), 32'd0);
        check("coinc_req", 32'(imem_req), 32'd1);
        check("coinc_addr", imem_addr, 32'h300);

        // Redirect beats stall in HAVE.
        fetch_to_have(32'h300, 32'h1234_5678, 0, 0);
        stall = 1'b1;
        tick();
        check("hs_valid", 32'(fetch_valid), 32'd1);
        redirect    = 1'b1;
        redirect_pc = 32'h40;
        tick();
        redirect = 1'b0;
        stall    = 1'b0;
        check("hs_valid0", 32'(fetch_valid), 32'd0);
        check("hs_instr0", next_instruction, 32'd0);
        check("hs_inced0", next_inced_pc, 32'd0);
        check("hs_req", 32'(imem_req), 32'd1);
        check("hs_addr", imem_addr, 32'h40);

        fetch_to_have(32'h40, 32'hAAAA_5555, 0, 1);
        consume(32'hAAAA_5555, 32'h44, 0, 32'h44);

        // Async reset while holding an instruction.
        fetch_to_have(32'h44, 32'h0F0F_F0F0, 0, 0);
        stall = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("arst_valid", 32'(fetch_valid), 32'd0);
        check("arst_instr", next_instruction, 32'd0);
        check("arst_inced", next_inced_pc, 32'd0);
        stall = 1'b0;
        tick();
        reset = 1'b1;
        check("arst_idle", 32'(imem_req), 32'd0);
        tick();
        check("arst_req", 32'(imem_req), 32'd1);
        check("arst_addr", imem_addr, 32'h0);
        check("arst_addr_w", imem_addr_w, 32'hFFFF_FFFC);

        // Async reset while in WAIT.
        imem_ready = 1'b1;
        tick();
        imem_ready = 1'b0;
        reset = 1'b0;
        #1;
        check("wrst_req", 32'(imem_req), 32'd0);
        check("wrst_addr", imem_addr, 32'd0);
        check("wrst_valid", 32'(fetch_valid), 32'd0);
        tick();
        reset = 1'b1;
        check("wrst_idle", 32'(imem_req), 32'd0);
        tick();
        check("wrst_req1", 32'(imem_req), 32'd1);
        check("wrst_addr0", imem_addr, 32'h0);

        fetch_to_have(32'h0, 32'h0000_0013, 1, 0);
        consume(32'h0000_0013, 32'h4, 2, 32'h4);

        tick();
        check("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
